// File: rtl/music_setting_arbiter_pkg.sv
// music_ctrl_pkg: command/state encodings and default setting limits shared with the tone generator.
package music_ctrl_pkg;
  typedef enum logic [1:0] {
    CMD_VOL_DN = 2'b00,
    CMD_VOL_UP = 2'b01,
    CMD_OCT_UP = 2'b10,
    CMD_OCT_DN = 2'b11
  } cmd_e;
  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_HOLDOFF} state_e;
  localparam int DEF_N_REQ       = 3;
  localparam int DEF_VOL_MIN     = 1;
  localparam int DEF_VOL_MAX     = 5;
  localparam int DEF_VOL_RST     = 3;
  localparam int DEF_OCT_MIN     = 1;
  localparam int DEF_OCT_MAX     = 3;
  localparam int DEF_OCT_RST     = 2;
  localparam int DEF_HOLDOFF_CYC = 4;
endpackage

// File: rtl/music_setting_arbiter_if.sv
// music_setting_if: requester command bus plus the published volume/octave settings.
interface music_setting_if #(parameter int N_REQ = 3);
  logic [N_REQ-1:0]   req;
  logic [2*N_REQ-1:0] cmd;
  logic [N_REQ-1:0]   ack;
  logic [2:0]         volume;
  logic [2:0]         octave;
  logic               changed;
  logic               sat;
  logic               busy;
  modport master(output req, cmd, input ack, volume, octave, changed, sat, busy);
  modport slave(input req, cmd, output ack, volume, octave, changed, sat, busy);
endinterface

// File: rtl/music_setting_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 3,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PW-1:0]    ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [PW-1:0]    idx_o,
  output logic             valid_o
);
  // Scan farthest offset first so the nearest request to ptr_i wins.
  always_comb begin
    idx_o = '0;
    valid_o = |req_i;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req_i[(int'(ptr_i) + k) % N_REQ]) idx_o = PW'((int'(ptr_i) + k) % N_REQ);
    grant_o = '0;
    grant_o[idx_o] = valid_o;
  end
endmodule

// File: rtl/music_setting_arbiter.sv
// music_setting_arbiter: round-robin served volume/octave step commands with clamp and hold-off.
// Define SETTING_WRAP_EN to wrap at the limits instead of clamping.
module music_setting_arbiter
  import music_ctrl_pkg::*;
#(
  parameter int N_REQ       = DEF_N_REQ,
  parameter int VOL_MIN     = DEF_VOL_MIN,
  parameter int VOL_MAX     = DEF_VOL_MAX,
  parameter int VOL_RST     = DEF_VOL_RST,
  parameter int OCT_MIN     = DEF_OCT_MIN,
  parameter int OCT_MAX     = DEF_OCT_MAX,
  parameter int OCT_RST     = DEF_OCT_RST,
  parameter int HOLDOFF_CYC = DEF_HOLDOFF_CYC
) (
  input logic             clk,
  input logic             rst_n,
  music_setting_if.slave  bus
);
  localparam int PW = $clog2(N_REQ);
  state_e           state_q;
  cmd_e             cmd_q, cmd_sel;
  logic [PW-1:0]    ptr_q, gidx;
  logic [N_REQ-1:0] grant, ack_q;
  logic             gvalid, changed_q, sat_q, busy_q;
  logic [2:0]       vol_q, oct_q, cur, lo, hi, nx_d;
  logic [7:0]       cnt_q;
  logic             is_vol, up, at_lim, clamp;

  rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_rr (
    .req_i(bus.req), .ptr_i(ptr_q), .grant_o(grant), .idx_o(gidx), .valid_o(gvalid)
  );

  // The same step logic yields changed/sat at grant and the register update in APPLY.
  always_comb begin
    cmd_sel = (state_q == S_IDLE) ? cmd_e'(bus.cmd[2*gidx +: 2]) : cmd_q;
    is_vol = (cmd_sel == CMD_VOL_DN) || (cmd_sel == CMD_VOL_UP);
    up = (cmd_sel == CMD_VOL_UP) || (cmd_sel == CMD_OCT_UP);
    cur = is_vol ? vol_q : oct_q;
    lo = is_vol ? 3'(VOL_MIN) : 3'(OCT_MIN);
    hi = is_vol ? 3'(VOL_MAX) : 3'(OCT_MAX);
    at_lim = up ? (cur == hi) : (cur == lo);
`ifdef SETTING_WRAP_EN
    nx_d = at_lim ? (up ? lo : hi) : (up ? cur + 3'd1 : cur - 3'd1);
    clamp = 1'b0;
`else
    nx_d = at_lim ? cur : (up ? cur + 3'd1 : cur - 3'd1);
    clamp = at_lim;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cmd_q <= CMD_VOL_DN;
      ptr_q <= '0;
      ack_q <= '0;
      changed_q <= 1'b0;
      sat_q <= 1'b0;
      busy_q <= 1'b0;
      vol_q <= 3'(VOL_RST);
      oct_q <= 3'(OCT_RST);
      cnt_q <= '0;
    end else begin
      ack_q <= '0;
      changed_q <= 1'b0;
      sat_q <= 1'b0;
      case (state_q)
        S_IDLE: if (gvalid) begin
          state_q <= S_APPLY;
          ack_q <= grant;
          cmd_q <= cmd_sel;
          ptr_q <= (gidx == PW'(N_REQ - 1)) ? '0 : PW'(gidx + 1'b1);
          changed_q <= !clamp;
          sat_q <= clamp;
          busy_q <= 1'b1;
        end
        S_APPLY: begin
          if (is_vol) vol_q <= nx_d;
          else oct_q <= nx_d;
          if (HOLDOFF_CYC > 0) begin
            state_q <= S_HOLDOFF;
            cnt_q <= 8'(HOLDOFF_CYC - 1);
          end else begin
            state_q <= S_IDLE;
            busy_q <= 1'b0;
          end
        end
        S_HOLDOFF: if (cnt_q == '0) begin
          state_q <= S_IDLE;
          busy_q <= 1'b0;
        end else cnt_q <= cnt_q - 8'd1;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ack = ack_q;
  assign bus.volume = vol_q;
  assign bus.octave = oct_q;
  assign bus.changed = changed_q;
  assign bus.sat = sat_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_music_setting_arbiter.sv
// tb_music_setting_arbiter: table-driven vectors with a scoreboard queue plus arbitration/reset corner sequences.
module tb_music_setting_arbiter;
  import music_ctrl_pkg::*;
  localparam int N = 3;

  typedef struct {
    int   r;
    cmd_e c;
    int   vol;
    int   oct;
    int   ch;
    int   st;
  } vec_t;

  logic clk = 0, rst_n = 0;
  int   n_vec = 0, n_err = 0, cyc = 0;
  vec_t tbl[$];
  vec_t sb[$];

  music_setting_if #(.N_REQ(N)) bus();
  music_setting_arbiter #(.N_REQ(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    bus.req = '0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic drive(input vec_t v);
    logic [2*N-1:0] cc;
    cc = (2*N)'($urandom);
    cc[2*v.r +: 2] = v.c;
    bus.cmd = cc;
    bus.req[v.r] = 1'b1;
    sb.push_back(v);
  endtask

  task automatic serve(input bit chk_lat, output int ack_cyc);
    int   n;
    vec_t e;
    n = 0;
    ack_cyc = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.ack == '0 && n < 40);
    if (bus.ack == '0) begin
      chk("ack_timeout", 0, 1);
      return;
    end
    if (sb.size() == 0) begin
      chk("unexpected_ack", int'(bus.ack), 0);
      return;
    end
    e = sb.pop_front();
    ack_cyc = cyc;
    chk("ack", int'(bus.ack), 1 << e.r);
    chk("changed", int'(bus.changed), e.ch);
    chk("sat", int'(bus.sat), e.st);
    chk("busy_apply", int'(bus.busy), 1);
    if (chk_lat) chk("latency", n, 1);
    bus.req[e.r] = 1'b0;
    @(negedge clk);
    chk("volume", int'(bus.volume), e.vol);
    chk("octave", int'(bus.octave), e.oct);
    chk("pulse_end", int'({bus.changed, bus.sat, |bus.ack}), 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", int'(bus.busy), 0);
  endtask

  initial begin
    int  t0, t1, t2;
    bit  seen;
    bus.req = '0;
    bus.cmd = '0;
`ifdef SETTING_WRAP_EN
    tbl.push_back('{0, CMD_OCT_DN, 3, 1, 1, 0});
    tbl.push_back('{0, CMD_OCT_DN, 3, 3, 1, 0});
    tbl.push_back('{1, CMD_OCT_UP, 3, 1, 1, 0});
    tbl.push_back('{2, CMD_VOL_UP, 4, 1, 1, 0});
    tbl.push_back('{2, CMD_VOL_UP, 5, 1, 1, 0});
    tbl.push_back('{1, CMD_VOL_UP, 1, 1, 1, 0});
    tbl.push_back('{0, CMD_VOL_DN, 5, 1, 1, 0});
`else
    tbl.push_back('{0, CMD_VOL_UP, 4, 2, 1, 0});
    tbl.push_back('{0, CMD_VOL_UP, 5, 2, 1, 0});
    tbl.push_back('{0, CMD_VOL_UP, 5, 2, 0, 1});
    tbl.push_back('{1, CMD_VOL_DN, 4, 2, 1, 0});
    tbl.push_back('{2, CMD_OCT_UP, 4, 3, 1, 0});
    tbl.push_back('{2, CMD_OCT_UP, 4, 3, 0, 1});
    tbl.push_back('{1, CMD_OCT_DN, 4, 2, 1, 0});
    tbl.push_back('{0, CMD_OCT_DN, 4, 1, 1, 0});
    tbl.push_back('{0, CMD_OCT_DN, 4, 1, 0, 1});
    tbl.push_back('{2, CMD_VOL_DN, 3, 1, 1, 0});
    tbl.push_back('{2, CMD_VOL_DN, 2, 1, 1, 0});
    tbl.push_back('{1, CMD_VOL_DN, 1, 1, 1, 0});
    tbl.push_back('{1, CMD_VOL_DN, 1, 1, 0, 1});
`endif
    do_reset();
    repeat (10) @(negedge clk);
    chk("rst_volume", int'(bus.volume), 3);
    chk("rst_octave", int'(bus.octave), 2);
    chk("rst_ack", int'(bus.ack), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_pulses", int'({bus.changed, bus.sat}), 0);

    foreach (tbl[i]) begin
      drive(tbl[i]);
      serve(1'b1, t0);
      wait_idle();
    end

    // All three request OCT_UP together: served 0,1,2 six cycles apart.
    do_reset();
    bus.cmd = {CMD_OCT_UP, CMD_OCT_UP, CMD_OCT_UP};
    bus.req = 3'b111;
`ifdef SETTING_WRAP_EN
    sb.push_back('{0, CMD_OCT_UP, 3, 3, 1, 0});
    sb.push_back('{1, CMD_OCT_UP, 3, 1, 1, 0});
    sb.push_back('{2, CMD_OCT_UP, 3, 2, 1, 0});
`else
    sb.push_back('{0, CMD_OCT_UP, 3, 3, 1, 0});
    sb.push_back('{1, CMD_OCT_UP, 3, 3, 0, 1});
    sb.push_back('{2, CMD_OCT_UP, 3, 3, 0, 1});
`endif
    serve(1'b1, t0);
    serve(1'b0, t1);
    serve(1'b0, t2);
    chk("rr_spacing_01", t1 - t0, 6);
    chk("rr_spacing_12", t2 - t1, 6);
    wait_idle();

    // A one-cycle request during hold-off must be lost.
    do_reset();
    drive('{0, CMD_VOL_UP, 4, 2, 1, 0});
    serve(1'b1, t0);
    bus.cmd[3:2] = CMD_VOL_UP;
    bus.req[1] = 1'b1;
    @(negedge clk);
    bus.req[1] = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.ack != '0) seen = 1;
    end
    chk("holdoff_pulse_ack", int'(seen), 0);
    chk("holdoff_pulse_vol", int'(bus.volume), 4);
    chk("holdoff_pulse_busy", int'(bus.busy), 0);

    // Reset asserted while APPLY is in progress.
    do_reset();
    bus.cmd = {2'b00, 2'b00, CMD_VOL_DN};
    bus.req = 3'b001;
    @(posedge clk);
    #1 rst_n = 0;
    bus.req = '0;
    @(negedge clk);
    chk("rst_apply_ack", int'(bus.ack), 0);
    chk("rst_apply_vol", int'(bus.volume), 3);
    chk("rst_apply_busy", int'(bus.busy), 0);
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.ack != '0 || bus.busy) seen = 1;
    end
    chk("rst_apply_quiet", int'(seen), 0);
    chk("rst_apply_vol_after", int'(bus.volume), 3);
    drive('{2, CMD_OCT_DN, 3, 1, 1, 0});
    serve(1'b1, t0);
    wait_idle();

    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/music_setting_arbiter.md
Name: music_setting_arbiter

Overview:
- Owns the shared volume/octave setting registers; several requesters (PS/2 keyboard front-end, board push-buttons, demo/auto-play sequencer) issue step commands over a req/ack handshake.
- Round-robin arbitration picks one command at a time, applies it with saturation, then enforces a hold-off interval.
- Outputs feed the tone generator (octave) and amplitude scaler (volume) directly.

Parameters:
- N_REQ, 3, number of requesters (2..8)
- VOL_MIN, 1, lowest volume
- VOL_MAX, 5, highest volume
- VOL_RST, 3, volume after reset
- OCT_MIN, 1, lowest octave
- OCT_MAX, 3, highest octave
- OCT_RST, 2, octave after reset
- HOLDOFF_CYC, 4, idle cycles after each applied command; 0 = none

Ports:
- clk  in  1  system clock, single clock domain
- rst_n  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester request, level, held until ack
- cmd  in  2*N_REQ  per-requester command, slice i = cmd[2i+1:2i]; 00 VOL_DN, 01 VOL_UP, 10 OCT_UP, 11 OCT_DN
- ack  out  N_REQ  one-hot, one-cycle pulse to the served requester
- volume  out  3  current volume
- octave  out  3  current octave
- changed  out  1  one-cycle pulse when volume or octave value actually changed
- sat  out  1  one-cycle pulse when an applied command was clamped (no change)
- busy  out  1  high in APPLY and HOLDOFF

Behaviour:
- Reset (rst_n low, async): volume=VOL_RST, octave=OCT_RST, ack=0, changed=0, sat=0, busy=0, state=IDLE, rr pointer=0, hold-off counter=0.
- FSM states: IDLE, APPLY, HOLDOFF.
- IDLE: if req!=0, grant the first set bit searching from index (ptr) upward, wrapping; latch grant index and its cmd; pointer becomes grant+1 mod N_REQ; next APPLY. Else stay.
- APPLY (exactly 1 cycle): ack[grant]=1 (Moore output); volume/octave register updated at end of this cycle; changed or sat pulses in this same cycle, computed from the current value and latched cmd. Next: HOLDOFF if HOLDOFF_CYC>0 else IDLE.
- HOLDOFF: counter loads HOLDOFF_CYC-1 on entry, decrements each cycle, exits to IDLE when 0; requests stay pending, not served.
- Latency: req sampled in IDLE at cycle t -> ack at t+1 -> new value visible t+2. Next grant no earlier than t+2+HOLDOFF_CYC.
- Saturation: VOL_DN at VOL_MIN, VOL_UP at VOL_MAX, OCT_DN at OCT_MIN, OCT_UP at OCT_MAX -> value held, sat=1, changed=0. Otherwise step by 1, changed=1, sat=0.
- Requester rules: hold req and cmd stable until ack; drop req the cycle after ack or re-present for a new command. Req removed before grant -> not served, no ack. Req dropped during APPLY -> latched command still applied, ack still pulsed.
- Simultaneous reqs: only one served per grant; others wait; a requester holding req continuously is served again only after all other pending requesters (rr fairness).
- cmd of non-requesting slots ignored.
- Reset mid-APPLY/HOLDOFF: abort, no ack, registers to reset values.

Optional Feature:
- SETTING_WRAP_EN: when defined, limits wrap instead of clamp (VOL_UP at VOL_MAX -> VOL_MIN, VOL_DN at VOL_MIN -> VOL_MAX; likewise octave); changed=1, sat never asserts. When undefined, saturate as above.

Decomposition:
- Package music_ctrl_pkg: command encodings (CMD_VOL_DN/UP, CMD_OCT_UP/DN), state encodings, default limit/reset constants shared with the tone generator.
- One sub-module rr_arbiter (req vector + pointer in, one-hot grant + index out, combinational); FSM, counters and setting registers stay in the top.

Test Plan:
- Reset then idle 10 cycles -> volume=3, octave=2, ack=0, busy=0.
- req[0]=1 cmd0=01 once -> ack[0] one cycle later, volume=4 the cycle after, changed pulse once; repeat twice -> volume 5, then sat=1, volume stays 5.
- req=3'b111 held, cmd all 10, HOLDOFF_CYC=4 -> acks in order 0,1,2 spaced 6 cycles; octave 2->3 then two sat pulses.
- req[1] pulsed 1 cycle during HOLDOFF, then dropped -> never acked, values unchanged.
- rst_n low during APPLY of VOL_DN from 3 -> no ack, volume=3, state IDLE after release.
- SETTING_WRAP_EN defined: OCT_DN x2 from 2 -> octave 1 then 3, changed both times, sat=0.
